clk_period_monitor: RTL and testbench
=====================================

CLK_PERIOD_MONITOR -- requirements
Module: clk_period_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of all duration counters and length outputs.
REQ-002 SHALL have parameter EXP_HALF, default 20: expected half-period of sig_in, in clk cycles.
REQ-003 SHALL have parameter TOL, default 2: allowed absolute deviation of each half-period, in clk cycles.
REQ-004 SHALL have parameter LOCK_N, default 4: consecutive in-tolerance full periods required to assert locked.
REQ-005 SHALL have parameter TIMEOUT, default 100: cycles without an edge before declaring stuck; TIMEOUT < 2**CNT_W.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port sig_in  input  1  monitored square wave, asynchronous to clk.
REQ-009 SHALL have port meas_valid  output  1  one-cycle pulse; a full period measurement is presented.
REQ-010 SHALL have port high_len  output  CNT_W  last measured high-phase length, in cycles.
REQ-011 SHALL have port low_len  output  CNT_W  last measured low-phase length, in cycles.
REQ-012 SHALL have port period_len  output  CNT_W+1  high_len + low_len of the last measurement.
REQ-013 SHALL have port half_err  output  1  one-cycle pulse; a completed half-phase was outside EXP_HALF±TOL.
REQ-014 SHALL have port stuck  output  1  one-cycle pulse; no edge for TIMEOUT cycles.
REQ-015 SHALL have port locked  output  1  level; LOCK_N consecutive good periods were seen since the last error.

Function
REQ-016 SHALL pass sig_in through a 2-flop synchronizer, then a third register s_d; rise = s & ~s_d, fall = ~s & s_d.
REQ-017 SHALL keep phase counter cnt: load 1 on any edge, else increment, saturating at 2**CNT_W-1.
REQ-018 SHALL define the completed phase length as the value of cnt in the edge cycle, before reload.
REQ-019 SHALL implement FSM states IDLE, HIGH and LOW; reset state is IDLE.
REQ-020 IDLE: on rise go to HIGH; on fall go to LOW; no measurement and no half_err for the partial phase.
REQ-021 HIGH: on fall, latch the completed length into a pending high register, check tolerance, go to LOW.
REQ-022 LOW: on rise, update high_len, low_len and period_len, pulse meas_valid on the next cycle, check tolerance, go to HIGH.
REQ-023 SHALL treat the first LOW phase entered from IDLE as partial: its rise goes to HIGH without meas_valid.
REQ-024 Tolerance check: phase is good iff EXP_HALF-TOL <= len <= EXP_HALF+TOL, using unsigned arithmetic with no underflow (lower bound clamps at 0); a bad phase pulses half_err the cycle after its edge.
REQ-025 Lock counter SHALL increment on each meas_valid whose high and low phases were both good, saturating at LOCK_N; locked = (count == LOCK_N).
REQ-026 Any half_err or stuck pulse SHALL clear the lock counter and deassert locked in the same cycle as the pulse.
REQ-027 When cnt reaches TIMEOUT with no edge, SHALL pulse stuck once, return to IDLE, and not pulse again until a new edge occurs.
REQ-028 An edge in the same cycle cnt reaches TIMEOUT SHALL take priority: the edge is processed normally and no stuck pulse occurs.
REQ-029 Outputs high_len, low_len and period_len SHALL hold their values between meas_valid pulses.

Reset
REQ-030 While rst_n = 0, SHALL drive all outputs, synchronizer flops, cnt, pending register and lock counter to 0, with FSM in IDLE.
REQ-031 On rst_n deassertion, SHALL start in IDLE with the synchronizer holding 0; a high sig_in then appears as a rise, which is handled as in IDLE.
REQ-032 Reset asserted mid-phase SHALL discard the partial measurement; no meas_valid, half_err or stuck pulse follows reset release until a new qualifying event.

Verification
REQ-033 Defaults; sig_in toggles every 20 cycles -> meas_valid every 40 cycles with high_len = 20, low_len = 20, period_len = 40; locked rises on the 4th meas_valid.
REQ-034 sig_in high 18 / low 22 -> measurements 18/22/40, no half_err, lock achieved; then one high phase of 25 -> half_err pulse and locked = 0; relock after 4 further good periods.
REQ-035 Lock established, then sig_in held high -> stuck pulses exactly once, 100 cycles after the last rise, with FSM in IDLE and locked = 0; the next toggling yields no meas_valid for the first partial period.
REQ-036 Reset asserted for 3 cycles, 10 cycles into a high phase -> all outputs 0 during reset; after release, no meas_valid until one complete low phase and high phase have been observed.
REQ-037 CNT_W = 8, TIMEOUT = 255, sig_in held low -> cnt saturates at 255 without wrap, and stuck pulses once.

Source files
------------

// File: rtl/clk_period_monitor.sv
// Measures the high and low phase lengths of an asynchronous square wave in clk cycles,
// flags out-of-tolerance half-periods and stuck inputs, and reports lock after LOCK_N good periods.
module clk_period_monitor #(
    parameter int CNT_W    = 16,
    parameter int EXP_HALF = 20,
    parameter int TOL      = 2,
    parameter int LOCK_N   = 4,
    parameter int TIMEOUT  = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W:0]   period_len,
    output logic             half_err,
    output logic             stuck,
    output logic             locked
);

    localparam int LCK_W = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);
    localparam logic [31:0]      LO_B    = (EXP_HALF > TOL) ? 32'(EXP_HALF - TOL) : 32'd0;
    localparam logic [31:0]      HI_B    = 32'(EXP_HALF + TOL);
    localparam logic [LCK_W-1:0] LOCK_V  = LCK_W'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } state_t;

    // Lower bound is pre-clamped at zero so the unsigned compare never underflows.
    function automatic logic in_tol(input logic [CNT_W-1:0] len);
        return (32'(len) >= LO_B) && (32'(len) <= HI_B);
    endfunction

    logic             r_sync1;
    logic             r_sync2;
    logic             r_s_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stuck_done;
    logic             r_partial;
    logic [CNT_W-1:0] r_pend_high;
    logic             r_pend_good;
    logic [LCK_W-1:0] r_lock_cnt;
    state_t           r_state;

    logic             r_meas_valid;
    logic [CNT_W-1:0] r_high_len;
    logic [CNT_W-1:0] r_low_len;
    logic [CNT_W:0]   r_period_len;
    logic             r_half_err;
    logic             r_stuck;
    logic             r_locked;

    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    logic             w_timeout;
    logic             w_len_good;
    logic             w_meas_nxt;
    logic             w_half_err_nxt;
    logic [LCK_W-1:0] w_lock_nxt;

    assign w_rise     = r_sync2 & ~r_s_d;
    assign w_fall     = ~r_sync2 & r_s_d;
    assign w_edge     = w_rise | w_fall;
    assign w_timeout  = (r_cnt == TO_V) && !w_edge && !r_stuck_done;
    assign w_len_good = in_tol(r_cnt);

    assign meas_valid = r_meas_valid;
    assign high_len   = r_high_len;
    assign low_len    = r_low_len;
    assign period_len = r_period_len;
    assign half_err   = r_half_err;
    assign stuck      = r_stuck;
    assign locked     = r_locked;

    // Next-cycle pulse decisions and lock counter update for the current edge.
    always_comb begin
        w_meas_nxt     = 1'b0;
        w_half_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_half_err_nxt = 1'b0;
            end
            HIGH: begin
                if (w_fall) begin
                    w_half_err_nxt = ~w_len_good;
                end else begin
                    w_half_err_nxt = 1'b0;
                end
            end
            LOW: begin
                if (w_rise && !r_partial) begin
                    w_meas_nxt     = 1'b1;
                    w_half_err_nxt = ~w_len_good;
                end else begin
                    w_meas_nxt     = 1'b0;
                end
            end
            default: begin
                w_half_err_nxt = 1'b0;
            end
        endcase

        if (w_half_err_nxt || w_timeout) begin
            w_lock_nxt = '0;
        end else if (w_meas_nxt && r_pend_good && w_len_good && (r_lock_cnt != LOCK_V)) begin
            w_lock_nxt = r_lock_cnt + LCK_W'(1);
        end else begin
            w_lock_nxt = r_lock_cnt;
        end
    end

    // Synchronizer, phase counter, FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_s_d        <= 1'b0;
            r_cnt        <= '0;
            r_stuck_done <= 1'b0;
            r_partial    <= 1'b0;
            r_pend_high  <= '0;
            r_pend_good  <= 1'b0;
            r_lock_cnt   <= '0;
            r_state      <= IDLE;
            r_meas_valid <= 1'b0;
            r_high_len   <= '0;
            r_low_len    <= '0;
            r_period_len <= '0;
            r_half_err   <= 1'b0;
            r_stuck      <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_s_d   <= r_sync2;

            if (w_edge) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end

            // Stuck fires once per silent stretch; only a fresh edge re-arms it.
            if (w_edge) begin
                r_stuck_done <= 1'b0;
            end else if (w_timeout) begin
                r_stuck_done <= 1'b1;
            end else begin
                r_stuck_done <= r_stuck_done;
            end

            r_meas_valid <= w_meas_nxt;
            r_half_err   <= w_half_err_nxt;
            r_stuck      <= w_timeout;
            r_lock_cnt   <= w_lock_nxt;
            r_locked     <= (w_lock_nxt == LOCK_V);

            if (w_meas_nxt) begin
                r_high_len   <= r_pend_high;
                r_low_len    <= r_cnt;
                r_period_len <= {1'b0, r_pend_high} + {1'b0, r_cnt};
            end else begin
                r_high_len   <= r_high_len;
                r_low_len    <= r_low_len;
                r_period_len <= r_period_len;
            end

            if (w_timeout) begin
                r_state   <= IDLE;
                r_partial <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state   <= HIGH;
                            r_partial <= 1'b0;
                        end else if (w_fall) begin
                            // Low phase began before we were watching; skip its measurement.
                            r_state   <= LOW;
                            r_partial <= 1'b1;
                        end else begin
                            r_state   <= IDLE;
                        end
                    end
                    HIGH: begin
                        if (w_fall) begin
                            r_pend_high <= r_cnt;
                            r_pend_good <= w_len_good;
                            r_state     <= LOW;
                            r_partial   <= 1'b0;
                        end else begin
                            r_state     <= HIGH;
                        end
                    end
                    LOW: begin
                        if (w_rise) begin
                            r_state   <= HIGH;
                            r_partial <= 1'b0;
                        end else begin
                            r_state   <= LOW;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_partial <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: table of square-wave periods with expected
// measurements, plus hand sequences for stuck, partial phases, reset and saturation.
module tb_clk_period_monitor;

    logic        clk;
    logic        rst_n;
    logic        sig_in;
    logic        meas_valid;
    logic [15:0] high_len;
    logic [15:0] low_len;
    logic [16:0] period_len;
    logic        half_err;
    logic        stuck;
    logic        locked;

    logic        sig8;
    logic        meas8;
    logic [7:0]  high8;
    logic [7:0]  low8;
    logic [8:0]  per8;
    logic        herr8;
    logic        stuck8;
    logic        lock8;

    clk_period_monitor dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_valid(meas_valid),
        .high_len(high_len), .low_len(low_len), .period_len(period_len),
        .half_err(half_err), .stuck(stuck), .locked(locked)
    );

    clk_period_monitor #(.CNT_W(8), .TIMEOUT(255)) dut8 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig8), .meas_valid(meas8),
        .high_len(high8), .low_len(low8), .period_len(per8),
        .half_err(herr8), .stuck(stuck8), .locked(lock8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] h;
        logic [15:0] l;
        logic [16:0] p;
        logic        lk;
    } meas_t;

    typedef struct {
        int   h;
        int   l;
        logic lk;
    } vec_t;

    meas_t mq[$];
    logic  he_lk[$];
    int    he_cnt  = 0;
    int    st_cnt  = 0;
    int    st_cyc  = 0;
    logic  st_lk   = 1'b0;
    int    st8_cnt = 0;
    int    cyc     = 0;
    int    checks  = 0;
    int    failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder sampled mid-cycle.
    always @(negedge clk) begin
        if (meas_valid) mq.push_back('{high_len, low_len, period_len, locked});
        if (half_err) begin
            he_cnt <= he_cnt + 1;
            he_lk.push_back(locked);
        end
        if (stuck) begin
            st_cnt <= st_cnt + 1;
            st_cyc <= cyc;
            st_lk  <= locked;
        end
        if (!rst_n) st8_cnt <= 0;
        else if (stuck8) st8_cnt <= st8_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        sig_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_meas(input string nm, input int idx, input int h, input int l, input logic lk);
        if (idx < mq.size()) begin
            chk({nm, "_high"},   32'(mq[idx].h),  32'(h));
            chk({nm, "_low"},    32'(mq[idx].l),  32'(l));
            chk({nm, "_period"}, 32'(mq[idx].p),  32'(h + l));
            chk({nm, "_locked"}, 32'(mq[idx].lk), 32'(lk));
        end else begin
            chk({nm, "_present"}, 32'(mq.size()), 32'(idx + 1));
        end
    endtask

    vec_t tbl[15];
    int   n0, he0, st0, rise_cyc;

    initial begin
        for (int i = 0; i < 6; i++) tbl[i] = '{20, 20, (i >= 3)};
        for (int i = 6; i < 10; i++) tbl[i] = '{18, 22, 1'b1};
        tbl[10] = '{25, 22, 1'b0};
        for (int i = 11; i < 15; i++) tbl[i] = '{18, 22, (i == 14)};

        rst_n  = 1'b0;
        sig_in = 1'b0;
        sig8   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst0_meas_valid", 32'(meas_valid), 32'd0);
        chk("rst0_half_err",   32'(half_err),   32'd0);
        chk("rst0_stuck",      32'(stuck),      32'd0);
        chk("rst0_locked",     32'(locked),     32'd0);
        chk("rst0_period",     32'(period_len), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven periods: nominal, edge-of-tolerance, one bad high, relock.
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, tbl[i].h);
            drive(1'b0, tbl[i].l);
        end
        sig_in   = 1'b1;
        rise_cyc = cyc;
        drive(1'b1, 6);
        chk("table_meas_count", 32'(mq.size()), 32'd15);
        for (int i = 0; i < 15; i++) chk_meas($sformatf("row%0d", i), i, tbl[i].h, tbl[i].l, tbl[i].lk);
        chk("table_half_err_count", 32'(he_cnt), 32'd1);
        if (he_lk.size() > 0) chk("half_err_unlocks", 32'(he_lk[0]), 32'd0);
        chk("locked_before_stuck", 32'(locked), 32'd1);

        // Hold high: a single stuck pulse TIMEOUT cycles after the synchronised rise
        // (two synchronizer stages plus the registered pulse add three cycles).
        st0 = st_cnt;
        drive(1'b1, 124);
        chk("stuck_once", 32'(st_cnt - st0), 32'd1);
        chk("stuck_delay", 32'(st_cyc - rise_cyc), 32'd103);
        chk("stuck_unlocks", 32'(st_lk), 32'd0);
        chk("stuck_state_idle", 32'(dut.r_state), 32'd0);
        drive(1'b1, 150);
        chk("stuck_no_repeat", 32'(st_cnt - st0), 32'd1);

        // First low after IDLE is partial and unchecked even though it is short.
        n0  = mq.size();
        he0 = he_cnt;
        drive(1'b0, 7);
        drive(1'b1, 20);
        drive(1'b0, 20);
        chk("partial_no_meas", 32'(mq.size()), 32'(n0));
        drive(1'b1, 6);
        chk("partial_meas_count", 32'(mq.size()), 32'(n0 + 1));
        chk_meas("after_partial", n0, 20, 20, 1'b0);
        chk("partial_no_half_err", 32'(he_cnt), 32'(he0));

        // Reset 10 cycles into a high phase.
        drive(1'b1, 4);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_meas_valid", 32'(meas_valid), 32'd0);
            chk("rst_high_len",   32'(high_len),   32'd0);
            chk("rst_low_len",    32'(low_len),    32'd0);
            chk("rst_period_len", 32'(period_len), 32'd0);
            chk("rst_half_err",   32'(half_err),   32'd0);
            chk("rst_stuck",      32'(stuck),      32'd0);
            chk("rst_locked",     32'(locked),     32'd0);
        end
        rst_n = 1'b1;
        n0  = mq.size();
        he0 = he_cnt;
        st0 = st_cnt;
        repeat (20) @(posedge clk);
        #1;
        drive(1'b0, 20);
        sig_in = 1'b1;
        drive(1'b1, 1);
        chk("post_rst_no_early_meas", 32'(mq.size()), 32'(n0));
        drive(1'b1, 5);
        chk("post_rst_meas_count", 32'(mq.size()), 32'(n0 + 1));
        chk_meas("post_rst", n0, 20, 20, 1'b0);
        chk("post_rst_no_half_err", 32'(he_cnt), 32'(he0));
        chk("post_rst_no_stuck", 32'(st_cnt), 32'(st0));

        // High phase of exactly TIMEOUT: the edge wins, so half_err but no stuck.
        drive(1'b1, 94);
        drive(1'b0, 20);
        drive(1'b1, 6);
        chk("edge_at_timeout_no_stuck", 32'(st_cnt), 32'(st0));
        chk("edge_at_timeout_half_err", 32'(he_cnt), 32'(he0 + 1));
        chk_meas("edge_at_timeout", n0 + 1, 100, 20, 1'b0);

        // Narrow counter instance, input low since reset release: saturate, stuck once.
        drive(1'b1, 150);
        chk("cnt8_saturated", 32'(dut8.r_cnt), 32'd255);
        chk("cnt8_stuck_once", 32'(st8_cnt), 32'd1);
        chk("cnt8_locked", 32'(lock8), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
